// File: rtl/key_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_scheduler_if
// Description : Key-event delivery bus between the scheduler and its single
//               consumer. valid/ready handshake carrying one buffered event.
//   evt_valid  : head event present (scheduler -> consumer)
//   evt_code   : head event scan code (scheduler -> consumer)
//   evt_repeat : head event is an auto-repeat (scheduler -> consumer)
//   evt_ready  : consumer accepts the head event (consumer -> scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_scheduler_if;
    logic       evt_valid;
    logic [8:0] evt_code;
    logic       evt_repeat;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_repeat,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_event_scheduler
// Description : Turns decoder make/break reports into discrete key events,
//               tracks one held key with auto-repeat, and queues events in a
//               first-word-fall-through FIFO read over a valid/ready bus.
//   clk, rst       : clock, asynchronous active-high reset
//   key_valid_i    : decoder strobe, last_change_i/key_is_down_i valid
//   last_change_i  : scan code of the reported key
//   key_is_down_i  : make (1) or break (0) of that key
//   enable_i       : low flushes the FIFO and discards new events
//   evt_if         : event bus (master side)
//   held_o         : a key is being tracked
//   held_code_o    : tracked key code, 0 when none
//   fifo_level_o   : number of queued events
//   overflow_cnt_o : events dropped on a full FIFO, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_scheduler #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      key_valid_i,
    input  wire logic [8:0]                last_change_i,
    input  wire logic                      key_is_down_i,
    input  wire logic                      enable_i,
    key_event_scheduler_if.master          evt_if,
    output logic                           held_o,
    output logic [8:0]                     held_code_o,
    output logic [$clog2(DEPTH):0]         fifo_level_o,
    output logic [7:0]                     overflow_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] C_FIRST_REP = CNT_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-RATE makes the next match land RATE cycles later.
    localparam logic [CNT_W-1:0] C_RELOAD    = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [PTR_W:0]   C_FULL      = (PTR_W + 1)'(DEPTH);

    // Entry layout: {scan code[8:0], repeat flag}
    logic [9:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             held_q, held_d;
    logic [8:0]       held_code_q, held_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       w_press, w_release, w_repeat, w_push_req;
    logic       w_full, w_valid, w_pop, w_push, w_drop;
    logic [9:0] w_push_data;
    logic [9:0] w_head;

    assign w_press    = key_valid_i & key_is_down_i & ~held_q;
    assign w_release  = key_valid_i & ~key_is_down_i & held_q
                        & (last_change_i == held_code_q);
    // A release in the same cycle suppresses a due repeat.
    assign w_repeat   = held_q & ~w_release & (cnt_q == C_FIRST_REP);
    assign w_push_req = w_press | w_repeat;
    assign w_push_data = w_press ? {last_change_i, 1'b0} : {held_code_q, 1'b1};

    assign w_full  = (level_q == C_FULL);
    assign w_valid = (level_q != '0);
    assign w_pop   = w_valid & evt_if.evt_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
    assign w_push  = w_push_req & enable_i & (~w_full | w_pop);
    assign w_drop  = w_push_req & enable_i & w_full & ~w_pop;

    always_comb begin
        held_d      = held_q;
        held_code_d = held_code_q;
        cnt_d       = cnt_q;
        if (w_press) begin
            held_d      = 1'b1;
            held_code_d = last_change_i;
            cnt_d       = '0;
        end else if (w_release) begin
            held_d      = 1'b0;
            held_code_d = '0;
            cnt_d       = '0;
        end else if (held_q) begin
            cnt_d = w_repeat ? C_RELOAD : cnt_q + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (!enable_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (w_drop && ovf_q != 8'hFF) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q      <= 1'b0;
            held_code_q <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= '0;
        end else begin
            held_q      <= held_d;
            held_code_q <= held_code_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_push_data;
        end
    end

    assign w_head            = w_valid ? mem_q[rd_ptr_q] : '0;
    assign evt_if.evt_valid  = w_valid;
    assign evt_if.evt_code   = w_head[9:1];
    assign evt_if.evt_repeat = w_head[0];
    assign held_o            = held_q;
    assign held_code_o       = held_code_q;
    assign fifo_level_o      = level_q;
    assign overflow_cnt_o    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_scheduler
// Description : Directed self-checking bench for key_event_scheduler with
//               REPEAT_DELAY=20, REPEAT_RATE=5, DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [8:0] last_change = '0;
    logic       key_is_down = 1'b0;
    logic       enable = 1'b1;
    logic       held;
    logic [8:0] held_code;
    logic [2:0] fifo_level;
    logic [7:0] overflow_cnt;

    int checks   = 0;
    int failures = 0;

    key_event_scheduler_if evt_if ();

    key_event_scheduler #(
        .DEPTH        (4),
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid_i    (key_valid),
        .last_change_i  (last_change),
        .key_is_down_i  (key_is_down),
        .enable_i       (enable),
        .evt_if         (evt_if.master),
        .held_o         (held),
        .held_code_o    (held_code),
        .fifo_level_o   (fifo_level),
        .overflow_cnt_o (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle decoder report, then strobe dropped.
    task automatic report(input logic [8:0] code, input logic down);
        key_valid   = 1'b1;
        last_change = code;
        key_is_down = down;
        tick();
        key_valid   = 1'b0;
    endtask

    logic [8:0] ovf_codes [6] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E};
    logic [8:0] drain     [4] = '{9'h016, 9'h01E, 9'h026, 9'h036};

    initial begin
        evt_if.evt_ready = 1'b0;

        // Reset state
        tick();
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_code", evt_if.evt_code, 0);
        chk("rst_repeat", evt_if.evt_repeat, 0);
        chk("rst_held", held, 0);
        chk("rst_held_code", held_code, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single press followed by a 32-cycle hold with auto-repeat
        evt_if.evt_ready = 1'b1;
        report(9'h016, 1'b1);
        for (int c = 1; c <= 32; c++) begin
            logic exp_v;
            exp_v = (c == 1) || (c == 21) || (c == 26) || (c == 31);
            chk("hold_valid", evt_if.evt_valid, exp_v);
            chk("hold_level", fifo_level, exp_v);
            chk("hold_held_code", held_code, 9'h016);
            if (exp_v) begin
                chk("hold_code", evt_if.evt_code, 9'h016);
                chk("hold_repeat", evt_if.evt_repeat, (c != 1));
            end
            if (c == 32) begin
                key_valid   = 1'b1;
                last_change = 9'h016;
                key_is_down = 1'b0;
            end
            tick();
            key_valid = 1'b0;
        end
        for (int c = 0; c < 30; c++) begin
            chk("post_rel_valid", evt_if.evt_valid, 0);
            chk("post_rel_held", held, 0);
            chk("post_rel_code", held_code, 0);
            tick();
        end

        // Multi-key: second press and its release are ignored
        report(9'h016, 1'b1);
        chk("mk_press_valid", evt_if.evt_valid, 1);
        chk("mk_press_code", evt_if.evt_code, 9'h016);
        report(9'h01E, 1'b1);
        chk("mk_2nd_valid", evt_if.evt_valid, 0);
        chk("mk_2nd_held_code", held_code, 9'h016);
        report(9'h01E, 1'b0);
        chk("mk_rel2_valid", evt_if.evt_valid, 0);
        chk("mk_rel2_held", held, 1);
        chk("mk_rel2_held_code", held_code, 9'h016);
        report(9'h016, 1'b0);
        chk("mk_rel_held", held, 0);
        chk("mk_rel_held_code", held_code, 0);
        chk("mk_rel_valid", evt_if.evt_valid, 0);

        // Overflow: six presses into a four-entry FIFO with no consumer
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            report(ovf_codes[i], 1'b1);
            report(ovf_codes[i], 1'b0);
        end
        chk("ovf_level", fifo_level, 4);
        chk("ovf_cnt", overflow_cnt, 2);
        chk("ovf_head", evt_if.evt_code, 9'h045);

        // Full FIFO: press and pop in the same cycle
        evt_if.evt_ready = 1'b1;
        key_valid   = 1'b1;
        last_change = 9'h036;
        key_is_down = 1'b1;
        tick();
        key_valid        = 1'b0;
        evt_if.evt_ready = 1'b0;
        chk("full_level", fifo_level, 4);
        chk("full_ovf", overflow_cnt, 2);
        report(9'h036, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", evt_if.evt_valid, 1);
            chk("drain_code", evt_if.evt_code, drain[i]);
            chk("drain_repeat", evt_if.evt_repeat, 0);
            evt_if.evt_ready = 1'b1;
            tick();
            evt_if.evt_ready = 1'b0;
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_empty", evt_if.evt_valid, 0);

        // Flush: three queued events, enable dropped while a new press arrives
        report(9'h01E, 1'b1);
        report(9'h01E, 1'b0);
        report(9'h026, 1'b1);
        report(9'h026, 1'b0);
        report(9'h025, 1'b1);
        report(9'h025, 1'b0);
        chk("fl_level3", fifo_level, 3);
        enable = 1'b0;
        report(9'h045, 1'b1);
        enable = 1'b1;
        chk("fl_level", fifo_level, 0);
        chk("fl_valid", evt_if.evt_valid, 0);
        chk("fl_ovf", overflow_cnt, 2);
        chk("fl_held", held, 1);
        chk("fl_held_code", held_code, 9'h045);
        for (int c = 1; c <= 20; c++) begin
            chk("fl_no_press_evt", evt_if.evt_valid, 0);
            tick();
        end
        chk("fl_rep_valid", evt_if.evt_valid, 1);
        chk("fl_rep_code", evt_if.evt_code, 9'h045);
        chk("fl_rep_repeat", evt_if.evt_repeat, 1);

        // Reset in the middle of a hold
        #2;
        rst = 1'b1;
        #1;
        chk("mr_held", held, 0);
        chk("mr_held_code", held_code, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_valid", evt_if.evt_valid, 0);
        chk("mr_ovf", overflow_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        evt_if.evt_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            chk("mr_no_evt", evt_if.evt_valid, 0);
            chk("mr_no_held", held, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
